// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// The CHK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package mips_loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_W         = 32;
   localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      ST_CHK  = 2'd3
`endif
   } state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a big-endian byte stream into 32-bit words. o_word_valid pulses for one
// cycle, the cycle after the fourth byte of a word is accepted.
module imem_byte_packer
   import mips_loader_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clear,
   input  logic              i_byte_valid,
   input  logic [7:0]        i_byte,
   output logic [1:0]        o_byte_cnt,
   output logic              o_word_valid,
   output logic [WORD_W-1:0] o_word
);

   logic [1:0]        r_cnt;
   logic [WORD_W-9:0] r_shift;
   logic [WORD_W-1:0] r_word;
   logic              r_word_valid;
   logic              w_last;

   assign w_last = (r_cnt == LAST_BYTE_IDX);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_cnt        <= '0;
         r_shift      <= '0;
         r_word_valid <= 1'b0;
      end else begin
         r_word_valid <= 1'b0;
         if (i_byte_valid) begin
            if (w_last) begin
               r_cnt        <= '0;
               r_word_valid <= 1'b1;
            end else begin
               r_cnt   <= r_cnt + 2'd1;
               r_shift <= {r_shift[WORD_W-17:0], i_byte};
            end
         end
      end
   end

   // The completed word is held until the next one, so it stays stable for the write.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_word <= '0;
      end else if (!i_clear && i_byte_valid && w_last) begin
         r_word <= {r_shift, i_byte};
      end
   end

   assign o_byte_cnt   = r_cnt;
   assign o_word_valid = r_word_valid;
   assign o_word       = r_word;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction memory and holds the core in reset
// until the image is in place. Define IMEM_LOADER_CHECKSUM_EN for the trailing checksum.
module imem_loader
   import mips_loader_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [ADDR_W:0]   i_num_words,
   input  logic              i_in_valid,
   input  logic [7:0]        i_in_data,
   output logic              o_in_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [WORD_W-1:0] o_mem_wdata,
   output logic              o_core_rst,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE_W   = {{ADDR_W{1'b0}}, 1'b1};

   state_t            r_state;
   logic              r_in_ready;
   logic              r_busy;
   logic              r_done;
   logic              r_core_rst;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_words_left;

   logic              w_xfer;
   logic              w_start_ok;
   logic              w_last_byte;
   logic              w_word_valid;
   logic [1:0]        w_byte_cnt;
   logic [WORD_W-1:0] w_word;
   logic [ADDR_W:0]   w_n_clamped;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [WORD_W-1:0] r_sum;
   logic              r_err;
`endif

   assign w_xfer      = i_in_valid && r_in_ready;
   assign w_start_ok  = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_last_byte = w_xfer && (w_byte_cnt == LAST_BYTE_IDX);
   assign w_n_clamped = (i_num_words > DEPTH_W) ? DEPTH_W : i_num_words;

   imem_byte_packer u_packer (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_clear      (w_start_ok),
      .i_byte_valid (w_xfer),
      .i_byte       (i_in_data),
      .o_byte_cnt   (w_byte_cnt),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_in_ready   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_core_rst   <= 1'b1;
         r_addr       <= '0;
         r_words_left <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_sum        <= '0;
         r_err        <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (i_start) begin
                  r_core_rst <= 1'b1;
                  r_done     <= 1'b0;
                  r_addr     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_sum      <= '0;
                  r_err      <= 1'b0;
`endif
                  if (i_num_words == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     r_state    <= ST_CHK;
                     r_in_ready <= 1'b1;
                     r_busy     <= 1'b1;
`else
                     r_state    <= ST_DONE;
                     r_done     <= 1'b1;
                     r_core_rst <= 1'b0;
`endif
                  end else begin
                     r_state      <= ST_LOAD;
                     r_words_left <= w_n_clamped;
                     r_in_ready   <= 1'b1;
                     r_busy       <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               // Stop accepting once the final byte of the last word is in.
               if (w_last_byte && (r_words_left == ONE_W)) begin
                  r_in_ready <= 1'b0;
               end
               if (w_word_valid) begin
                  r_words_left <= r_words_left - ONE_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_sum        <= r_sum + w_word;
`endif
                  if (r_words_left == ONE_W) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     r_state    <= ST_CHK;
                     r_in_ready <= 1'b1;
`else
                     r_state    <= ST_DONE;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                     r_core_rst <= 1'b0;
`endif
                  end else begin
                     r_addr <= r_addr + 1'b1;
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
               if (w_last_byte) begin
                  r_in_ready <= 1'b0;
               end
               if (w_word_valid) begin
                  r_state    <= ST_DONE;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  r_err      <= (w_word != r_sum);
                  r_core_rst <= (w_word != r_sum);
               end
            end
`endif
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_mem_we    = w_word_valid && (r_state == ST_LOAD);
   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = w_word;
   assign o_core_rst  = r_core_rst;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign o_err       = r_err;
`else
   assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader, built with a 4-word memory so the depth clamp is reachable.
module tb_imem_loader;

   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW:0]   num_words;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          core_rst;
   logic          busy;
   logic          done;
   logic          err;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int fall_cyc = -1;
   int wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int wr_cyc_q[$];
   bit ready_seen = 1'b0;
   bit prev_core_rst = 1'b1;
   logic [31:0] w5 [4] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};

   imem_loader #(.ADDR_W(AW)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_num_words (num_words),
      .i_in_valid  (in_valid),
      .i_in_data   (in_data),
      .o_in_ready  (in_ready),
      .o_mem_we    (mem_we),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .o_core_rst  (core_rst),
      .o_busy      (busy),
      .o_done      (done),
      .o_err       (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (mem_we) begin
         wr_addr_q.push_back(int'(mem_addr));
         wr_data_q.push_back(mem_wdata);
         wr_cyc_q.push_back(cyc);
         $display("write addr=%0d data=%08h cycle=%0d", mem_addr, mem_wdata, cyc);
      end
      if (in_ready) ready_seen = 1'b1;
      if (prev_core_rst && !core_rst) fall_cyc = cyc;
      prev_core_rst = core_rst;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, got, exp);
      end
   endtask

   function automatic int get_addr(input int i);
      return (i < wr_addr_q.size()) ? wr_addr_q[i] : -1;
   endfunction

   function automatic logic [31:0] get_data(input int i);
      return (i < wr_data_q.size()) ? wr_data_q[i] : 32'hxxxxxxxx;
   endfunction

   function automatic int get_cyc(input int i);
      return (i < wr_cyc_q.size()) ? wr_cyc_q[i] : -100;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
      fall_cyc = -1;
      ready_seen = 1'b0;
   endtask

   task automatic do_start(input logic [AW:0] n);
      start = 1'b1;
      num_words = n;
      step();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit took;
      took = 1'b0;
      in_valid = 1'b1;
      in_data = b;
      for (int k = 0; k < 40 && !took; k++) begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!took) check("byte_accept_timeout", 32'(took), 32'd1);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int j = 0; j < 4; j++) send_byte(w[31-8*j -: 8]);
   endtask

   task automatic send_chk(input logic [31:0] sum);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(sum);
`else
      if (sum === 32'hxxxxxxxx) $display("checksum word unused");
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      num_words = '0;
      in_valid = 1'b0;
      in_data = 8'h00;
      step();
      step();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_core_rst", 32'(core_rst), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      step();

      // Two words back-to-back.
      clear_log();
      do_start(3'd2);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_in_ready", 32'(in_ready), 32'd1);
      check("t1_core_rst_held", 32'(core_rst), 32'd1);
      send_word(32'h8C010004);
      send_word(32'h00000008);
      send_chk(32'h8C01000C);
      repeat (3) step();
      check("t1_wr_count", 32'(wr_addr_q.size()), 32'd2);
      check("t1_addr0", 32'(get_addr(0)), 32'd0);
      check("t1_data0", get_data(0), 32'h8C010004);
      check("t1_addr1", 32'(get_addr(1)), 32'd1);
      check("t1_data1", get_data(1), 32'h00000008);
`ifndef IMEM_LOADER_CHECKSUM_EN
      check("t1_rst_fall_cycle", 32'(fall_cyc), 32'(get_cyc(1) + 1));
`endif
      check("t1_done", 32'(done), 32'd1);
      check("t1_core_rst", 32'(core_rst), 32'd0);
      check("t1_busy_end", 32'(busy), 32'd0);
      check("t1_in_ready_end", 32'(in_ready), 32'd0);

      // Reload from DONE with a 3-cycle gap between bytes 2 and 3.
      clear_log();
      do_start(3'd2);
      check("t2_done_cleared", 32'(done), 32'd0);
      check("t2_core_rst_set", 32'(core_rst), 32'd1);
      send_byte(8'h8C);
      send_byte(8'h01);
      repeat (3) step();
      check("t2_no_early_we", 32'(wr_addr_q.size()), 32'd0);
      send_byte(8'h00);
      send_byte(8'h04);
      send_word(32'h00000008);
      send_chk(32'h8C01000C);
      repeat (3) step();
      check("t2_wr_count", 32'(wr_addr_q.size()), 32'd2);
      check("t2_addr0", 32'(get_addr(0)), 32'd0);
      check("t2_data0", get_data(0), 32'h8C010004);
      check("t2_addr1", 32'(get_addr(1)), 32'd1);
      check("t2_data1", get_data(1), 32'h00000008);
      check("t2_done", 32'(done), 32'd1);
      check("t2_core_rst", 32'(core_rst), 32'd0);

      // Zero-length image.
      clear_log();
      do_start(3'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
      check("t3_done_next", 32'(done), 32'd1);
      check("t3_core_rst", 32'(core_rst), 32'd0);
      repeat (3) step();
      check("t3_ready_never", 32'(ready_seen), 32'd0);
`else
      send_chk(32'h00000000);
      repeat (2) step();
      check("t3_done", 32'(done), 32'd1);
      check("t3_core_rst", 32'(core_rst), 32'd0);
      check("t3_err", 32'(err), 32'd0);
`endif
      check("t3_no_write", 32'(wr_addr_q.size()), 32'd0);

      // Reset after six bytes of a two-word load.
      clear_log();
      do_start(3'd2);
      send_word(32'h8C010004);
      send_byte(8'h00);
      send_byte(8'h00);
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (2) step();
      check("t4_wr_count", 32'(wr_addr_q.size()), 32'd1);
      check("t4_addr0", 32'(get_addr(0)), 32'd0);
      check("t4_data0", get_data(0), 32'h8C010004);
      check("t4_core_rst", 32'(core_rst), 32'd1);
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_done", 32'(done), 32'd0);
      check("t4_in_ready", 32'(in_ready), 32'd0);
      clear_log();
      do_start(3'd1);
      send_word(32'hDEADBEEF);
      send_chk(32'hDEADBEEF);
      repeat (3) step();
      check("t4_reload_count", 32'(wr_addr_q.size()), 32'd1);
      check("t4_reload_addr", 32'(get_addr(0)), 32'd0);
      check("t4_reload_data", get_data(0), 32'hDEADBEEF);
      check("t4_reload_done", 32'(done), 32'd1);

      // Request 7 words into a 4-word memory: clamped to 4.
      clear_log();
      do_start(3'd7);
      for (int i = 0; i < 4; i++) send_word(w5[i]);
      send_chk(32'h181C2024);
`ifndef IMEM_LOADER_CHECKSUM_EN
      in_valid = 1'b1;
      in_data = 8'hAA;
      repeat (3) step();
      in_valid = 1'b0;
`endif
      repeat (2) step();
      check("t5_wr_count", 32'(wr_addr_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t5_addr%0d", i), 32'(get_addr(i)), 32'(i));
         check($sformatf("t5_data%0d", i), get_data(i), w5[i]);
      end
      check("t5_done", 32'(done), 32'd1);
      check("t5_core_rst", 32'(core_rst), 32'd0);
      check("t5_in_ready", 32'(in_ready), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum match, then mismatch.
      clear_log();
      do_start(3'd1);
      send_word(32'h00000005);
      send_word(32'h00000005);
      repeat (2) step();
      check("t6_ok_err", 32'(err), 32'd0);
      check("t6_ok_core_rst", 32'(core_rst), 32'd0);
      check("t6_ok_wr_count", 32'(wr_addr_q.size()), 32'd1);
      do_start(3'd1);
      check("t6_err_cleared", 32'(err), 32'd0);
      send_word(32'h00000005);
      send_word(32'h00000006);
      repeat (2) step();
      check("t6_bad_err", 32'(err), 32'd1);
      check("t6_bad_core_rst", 32'(core_rst), 32'd1);
      check("t6_bad_done", 32'(done), 32'd1);
`else
      check("t6_err_const", 32'(err), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
